// File: rtl/wb_sw_master_pkg.sv
// Shared constants for the switch-driven Wishbone initiator.
// FSM encodings, byte-select constant and default target address.
package wb_sw_master_pkg;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_WR   = 3'd1;
  localparam logic [2:0] ST_GAP  = 3'd2;
  localparam logic [2:0] ST_RD   = 3'd3;
  localparam logic [2:0] ST_FIN  = 3'd4;

  localparam logic [3:0]  SEL_ALL = 4'b1111;

  localparam logic [31:0] TARGET_ADR_DEFAULT = 32'h0000_0010;

endpackage

// File: rtl/wb_sw_master_debounce.sv
// Button conditioner: 2-FF synchroniser, stable-count debounce, rise pulse.
// Ports: clk, reset (sync, active-low), raw_i -> level_o, rise_o.
module sw_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o
);

  localparam int CW =
    (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1_q, s2_q, prev_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          rise_q, rise_d;

  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    if (s2_q != prev_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      // counter parks at max while the input stays put
      level_d = s2_q;
      rise_d  = s2_q & ~level_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      prev_q  <= 1'b0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      s1_q    <= raw_i;
      s2_q    <= s1_q;
      prev_q  <= s2_q;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;

endmodule

// File: rtl/wb_sw_master.sv
// Wishbone initiator: button press writes switches, reads back, checks.
// Ports: clk, reset(n), sw_in, btn_go, wb_* master, busy, done, err, rd_data.
module wb_sw_master
  import wb_sw_master_pkg::*;
#(
  parameter int          DEBOUNCE_CYCLES = 500000,
  parameter logic [31:0] TARGET_ADR      = TARGET_ADR_DEFAULT,
  parameter int          TIMEOUT_CYCLES  = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] sw_in,
  input  logic        btn_go,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_adr_o,
  output logic [3:0]  wb_sel_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rd_data
);

  localparam logic [8:0] TMO_LIM = 9'(TIMEOUT_CYCLES);

  logic [15:0] sw_s1_q, sw_s2_q;
  logic        btn_lvl, btn_rise, go_evt;

  logic [2:0]  state_q, state_d;
  logic        cyc_q, cyc_d;
  logic        stb_q, stb_d;
  logic        we_q, we_d;
  logic [31:0] dat_o_q, dat_o_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [31:0] rd_data_q, rd_data_d;
  logic [7:0]  tmo_q, tmo_d;

  logic        tmo_hit;
  logic [7:0]  tmo_inc;

  sw_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn (
    .clk    (clk),
    .reset  (reset),
    .raw_i  (btn_go),
    .level_o(btn_lvl),
    .rise_o (btn_rise)
  );

  assign go_evt = btn_rise & btn_lvl;

  // abort on the access cycle that would exceed the budget
  assign tmo_hit = ({1'b0, tmo_q} + 9'd1) >= TMO_LIM;
  assign tmo_inc = (tmo_q == 8'hFF) ? tmo_q : tmo_q + 8'd1;

  always_comb begin
    state_d   = state_q;
    cyc_d     = cyc_q;
    stb_d     = stb_q;
    we_d      = we_q;
    dat_o_d   = dat_o_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = err_q;
    rd_data_d = rd_data_q;
    tmo_d     = tmo_q;
    unique case (1'b1)
      (state_q == ST_IDLE): begin
        if (go_evt) begin
          dat_o_d = {16'b0, sw_s2_q};
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          we_d    = 1'b1;
          busy_d  = 1'b1;
          tmo_d   = '0;
          state_d = ST_WR;
        end
      end
      (state_q == ST_WR): begin
        if (wb_ack_i) begin
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          we_d    = 1'b0;
          state_d = ST_GAP;
        end else if (tmo_hit) begin
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          we_d    = 1'b0;
          err_d   = 1'b1;
          state_d = ST_FIN;
        end else begin
          tmo_d = tmo_inc;
        end
      end
      (state_q == ST_GAP): begin
        cyc_d   = 1'b1;
        stb_d   = 1'b1;
        we_d    = 1'b0;
        tmo_d   = '0;
        state_d = ST_RD;
      end
      (state_q == ST_RD): begin
        if (wb_ack_i) begin
          rd_data_d = wb_dat_i;
          cyc_d     = 1'b0;
          stb_d     = 1'b0;
          if (wb_dat_i != dat_o_q) err_d = 1'b1;
          state_d   = ST_FIN;
        end else if (tmo_hit) begin
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          err_d   = 1'b1;
          state_d = ST_FIN;
        end else begin
          tmo_d = tmo_inc;
        end
      end
      (state_q == ST_FIN): begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        cyc_d   = 1'b0;
        stb_d   = 1'b0;
        we_d    = 1'b0;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sw_s1_q   <= '0;
      sw_s2_q   <= '0;
      state_q   <= ST_IDLE;
      cyc_q     <= 1'b0;
      stb_q     <= 1'b0;
      we_q      <= 1'b0;
      dat_o_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      rd_data_q <= '0;
      tmo_q     <= '0;
    end else begin
      sw_s1_q   <= sw_in;
      sw_s2_q   <= sw_s1_q;
      state_q   <= state_d;
      cyc_q     <= cyc_d;
      stb_q     <= stb_d;
      we_q      <= we_d;
      dat_o_q   <= dat_o_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      rd_data_q <= rd_data_d;
      tmo_q     <= tmo_d;
    end
  end

  assign wb_cyc_o = cyc_q;
  assign wb_stb_o = stb_q;
  assign wb_we_o  = we_q;
  assign wb_adr_o = TARGET_ADR;
  assign wb_sel_o = SEL_ALL;
  assign wb_dat_o = dat_o_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_wb_sw_master.sv
// Directed bench for wb_sw_master with a small Wishbone target model.
// Each scenario task drives stimulus and checks its own results.
module tb_wb_sw_master;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] sw_in;
  logic        btn_go;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [31:0] wb_adr_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;
  logic        busy, done, err;
  logic [31:0] rd_data;

  int checks = 0;
  int errors = 0;

  wb_sw_master #(
    .DEBOUNCE_CYCLES(8),
    .TARGET_ADR     (32'h0000_0010),
    .TIMEOUT_CYCLES (15)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .sw_in   (sw_in),
    .btn_go  (btn_go),
    .wb_cyc_o(wb_cyc_o),
    .wb_stb_o(wb_stb_o),
    .wb_we_o (wb_we_o),
    .wb_adr_o(wb_adr_o),
    .wb_sel_o(wb_sel_o),
    .wb_dat_o(wb_dat_o),
    .wb_dat_i(wb_dat_i),
    .wb_ack_i(wb_ack_i),
    .busy    (busy),
    .done    (done),
    .err     (err),
    .rd_data (rd_data)
  );

  always #5 clk = ~clk;

  // target: acks after ack_dly extra cycles of stb, one-cycle ack
  logic        ack_en = 1'b1;
  int          ack_dly = 0;
  int          wcnt = 0;
  logic        ack_q = 1'b0;
  logic [31:0] rd_val = '0;

  assign wb_ack_i = ack_q;
  assign wb_dat_i = rd_val;

  always @(posedge clk) begin
    if (!ack_en || !(wb_cyc_o && wb_stb_o) || ack_q) begin
      ack_q <= 1'b0;
      wcnt  <= 0;
    end else if (wcnt == ack_dly) begin
      ack_q <= 1'b1;
      wcnt  <= 0;
    end else begin
      wcnt <= wcnt + 1;
    end
  end

  // monitor, sampled on the falling edge
  int          cy = 0;
  int          wr_n, rd_n, done_n, go_n, stb_cy, rd_stb_cy;
  int          bus_viol, busy_falls, low_run, last_gap;
  int          go_cy, done_cy;
  logic [31:0] wr_dat, wr_adr;
  logic [3:0]  wr_sel;
  logic        busy_prev = 1'b0;

  always @(posedge clk) cy <= cy + 1;

  always @(negedge clk) begin
    if (wb_stb_o && !wb_cyc_o) bus_viol <= bus_viol + 1;
    if (wb_stb_o) stb_cy <= stb_cy + 1;
    if (wb_stb_o && !wb_we_o) rd_stb_cy <= rd_stb_cy + 1;
    if (wb_stb_o && wb_ack_i) begin
      if (wb_we_o) begin
        wr_n   <= wr_n + 1;
        wr_dat <= wb_dat_o;
        wr_adr <= wb_adr_o;
        wr_sel <= wb_sel_o;
      end else begin
        rd_n <= rd_n + 1;
      end
    end
    if (!wb_stb_o) begin
      low_run <= low_run + 1;
    end else begin
      if (low_run != 0) last_gap <= low_run;
      low_run <= 0;
    end
    if (busy_prev && !busy) busy_falls <= busy_falls + 1;
    busy_prev <= busy;
    if (dut.go_evt) begin
      go_n  <= go_n + 1;
      go_cy <= cy;
    end
    if (done) begin
      done_n  <= done_n + 1;
      done_cy <= cy;
    end
  end

  task automatic clr();
    wr_n = 0; rd_n = 0; done_n = 0; go_n = 0;
    stb_cy = 0; rd_stb_cy = 0; bus_viol = 0;
    busy_falls = 0; low_run = 0; last_gap = 0;
    go_cy = 0; done_cy = 0;
    wr_dat = '0; wr_adr = '0; wr_sel = '0;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // 20 cycles of chatter, then held high
  task automatic press();
    int d [10] = '{1, 2, 3, 1, 2, 3, 1, 2, 3, 2};
    btn_go = 1'b0;
    for (int i = 0; i < 10; i++) begin
      btn_go = ~btn_go;
      tick(d[i]);
    end
    btn_go = 1'b1;
  endtask

  task automatic release_btn();
    btn_go = 1'b0;
    tick(20);
  endtask

  task automatic wait_done(input int lim, input string nm);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s done_timeout got 0 want 1", nm);
    end
    tick(3);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    reset = 1'b0;
    tick(n);
    reset = 1'b1;
    tick(2);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    btn_go = 1'b0;
    sw_in = '0;
    tick(5);
    checks++;
    if ({wb_cyc_o, wb_stb_o, wb_we_o, busy, done, err} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl got %b want 000000",
        {wb_cyc_o, wb_stb_o, wb_we_o, busy, done, err});
    end
    checks++;
    if (wb_dat_o !== 32'h0 || rd_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_data got %h/%h want 0/0", wb_dat_o, rd_data);
    end
    checks++;
    if (wb_adr_o !== 32'h10 || wb_sel_o !== 4'hF) begin
      errors++;
      $display("FAIL const_bus got %h/%h want 10/f", wb_adr_o, wb_sel_o);
    end
    reset = 1'b1;
    tick(2);
  endtask

  task automatic test_write_read();
    ack_en = 1'b1; ack_dly = 0;
    sw_in = 16'hA5C3; rd_val = 32'h0000A5C3;
    clr();
    press();
    wait_done(200, "wr_rd");
    tick(10);
    checks++;
    if (wr_n !== 1 || rd_n !== 1) begin
      errors++;
      $display("FAIL wr_rd_count got %0d/%0d want 1/1", wr_n, rd_n);
    end
    checks++;
    if (wr_dat !== 32'h0000A5C3) begin
      errors++;
      $display("FAIL wr_data got %h want 0000a5c3", wr_dat);
    end
    checks++;
    if (wr_adr !== 32'h10 || wr_sel !== 4'hF) begin
      errors++;
      $display("FAIL wr_adr_sel got %h/%h want 10/f", wr_adr, wr_sel);
    end
    checks++;
    if (done_n !== 1 || err !== 1'b0) begin
      errors++;
      $display("FAIL wr_rd_done_err got %0d/%b want 1/0", done_n, err);
    end
    checks++;
    if (rd_data !== 32'h0000A5C3) begin
      errors++;
      $display("FAIL wr_rd_rdata got %h want 0000a5c3", rd_data);
    end
    release_btn();
    checks++;
    if (wr_n !== 1 || bus_viol !== 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL after_release got wr%0d viol%0d busy%b want 1/0/0",
        wr_n, bus_viol, busy);
    end
  endtask

  task automatic test_latency();
    ack_en = 1'b1; ack_dly = 0;
    sw_in = 16'h1234; rd_val = 32'h00001234;
    clr();
    press();
    wait_done(200, "latency");
    checks++;
    if (done_cy - go_cy !== 7) begin
      errors++;
      $display("FAIL go_to_done got %0d want 7", done_cy - go_cy);
    end
    checks++;
    if (last_gap !== 1) begin
      errors++;
      $display("FAIL stb_gap got %0d want 1", last_gap);
    end
    checks++;
    if (rd_n !== 1 || err !== 1'b0) begin
      errors++;
      $display("FAIL latency_rd got %0d/%b want 1/0", rd_n, err);
    end
    release_btn();
  endtask

  task automatic test_busy_ignore();
    logic seen;
    ack_en = 1'b1; ack_dly = 12;
    sw_in = 16'h0F0F; rd_val = 32'h00000F0F;
    clr();
    press();
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick(1);
      if (busy) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL busy_start got 0 want 1");
    end
    btn_go = 1'b0;
    tick(12);
    btn_go = 1'b1;
    tick(12);
    checks++;
    if (busy !== 1'b1 || go_n !== 2) begin
      errors++;
      $display("FAIL second_go_while_busy got busy%b go%0d want 1/2",
        busy, go_n);
    end
    wait_done(300, "busy_ignore");
    tick(40);
    checks++;
    if (wr_n !== 1 || rd_n !== 1 || done_n !== 1) begin
      errors++;
      $display("FAIL busy_ignore got wr%0d rd%0d done%0d want 1/1/1",
        wr_n, rd_n, done_n);
    end
    checks++;
    if (busy_falls !== 1) begin
      errors++;
      $display("FAIL busy_continuous got %0d want 1", busy_falls);
    end
    release_btn();
    ack_dly = 0;
  endtask

  task automatic test_mismatch();
    ack_en = 1'b1; ack_dly = 0;
    sw_in = 16'hA5C3; rd_val = 32'h0000A5C2;
    clr();
    press();
    wait_done(200, "mismatch");
    tick(5);
    checks++;
    if (rd_data !== 32'h0000A5C2 || err !== 1'b1) begin
      errors++;
      $display("FAIL mismatch got %h/%b want 0000a5c2/1", rd_data, err);
    end
    checks++;
    if (done_n !== 1) begin
      errors++;
      $display("FAIL mismatch_done got %0d want 1", done_n);
    end
    release_btn();
    sw_in = 16'h5A5A; rd_val = 32'h00005A5A;
    clr();
    press();
    wait_done(200, "sticky");
    checks++;
    if (err !== 1'b1 || rd_data !== 32'h00005A5A || done_n !== 1) begin
      errors++;
      $display("FAIL err_sticky got %b/%h/%0d want 1/00005a5a/1",
        err, rd_data, done_n);
    end
    release_btn();
  endtask

  task automatic test_timeout();
    do_reset(2);
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL err_cleared got %b want 0", err);
    end
    ack_en = 1'b0;
    sw_in = 16'h00FF;
    clr();
    press();
    wait_done(200, "timeout");
    checks++;
    if (stb_cy !== 15) begin
      errors++;
      $display("FAIL timeout_stb_cycles got %0d want 15", stb_cy);
    end
    checks++;
    if (rd_stb_cy !== 0 || wr_n !== 0) begin
      errors++;
      $display("FAIL timeout_no_read got %0d/%0d want 0/0",
        rd_stb_cy, wr_n);
    end
    checks++;
    if (err !== 1'b1 || done_n !== 1 || wb_cyc_o !== 1'b0) begin
      errors++;
      $display("FAIL timeout_err got %b/%0d/%b want 1/1/0",
        err, done_n, wb_cyc_o);
    end
    release_btn();
    ack_en = 1'b1;
  endtask

  task automatic test_reset_mid();
    logic seen;
    ack_en = 1'b0;
    sw_in = 16'hBEEF;
    press();
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick(1);
      if (wb_stb_o) begin
        seen = 1'b1;
        break;
      end
    end
    tick(3);
    checks++;
    if (!seen || err !== 1'b1 || wb_dat_o !== 32'h0000BEEF) begin
      errors++;
      $display("FAIL pre_reset got stb%b err%b dat%h want 1/1/0000beef",
        seen, err, wb_dat_o);
    end
    @(negedge clk);
    reset = 1'b0;
    btn_go = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if ({wb_cyc_o, wb_stb_o, wb_we_o, busy, err, done} !== 6'b0) begin
      errors++;
      $display("FAIL mid_reset got %b want 000000",
        {wb_cyc_o, wb_stb_o, wb_we_o, busy, err, done});
    end
    checks++;
    if (wb_dat_o !== 32'h0) begin
      errors++;
      $display("FAIL mid_reset_dat got %h want 0", wb_dat_o);
    end
    tick(4);
    reset = 1'b1;
    tick(20);
    checks++;
    if (dut.state_q !== 3'd0 || busy !== 1'b0 || wb_cyc_o !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle got st%0d busy%b cyc%b want 0/0/0",
        dut.state_q, busy, wb_cyc_o);
    end
    ack_en = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  initial begin
    clr();
    test_reset();
    test_write_read();
    test_latency();
    test_busy_ignore();
    test_mismatch();
    test_timeout();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_sw_master.md
Name: wb_sw_master

Overview:
Wishbone initiator that turns board switches and a push-button into bus transactions.
- On a debounced button press, writes the synchronised 16-bit switch value to a target register (default: the BCD display "number" register, offset 0x10).
- Reads the same register back, checks it and reports error or success.
- Provides a CPU-independent path for driving and self-checking display peripherals in lab bring-up.

Parameters:
- DEBOUNCE_CYCLES, 500000, stable cycles required on btn_go before a press is accepted (10 ms at 50 MHz).
- TARGET_ADR, 32'h0000_0010, byte address used for both write and readback.
- TIMEOUT_CYCLES, 255, max cycles waiting for wb_ack_i per access before abort; 8-bit counter.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset (0 = reset).
- sw_in  in  16  raw asynchronous switches.
- btn_go  in  1  raw asynchronous push-button, active-high.
- wb_cyc_o  out  1  Wishbone cycle.
- wb_stb_o  out  1  Wishbone strobe.
- wb_we_o  out  1  1 = write, 0 = read.
- wb_adr_o  out  32  address; always TARGET_ADR.
- wb_sel_o  out  4  byte selects; always 4'b1111.
- wb_dat_o  out  32  write data, {16'b0, latched switches}.
- wb_dat_i  in  32  read data.
- wb_ack_i  in  1  target acknowledge.
- busy  out  1  high from transaction start until return to IDLE.
- done  out  1  one-cycle pulse when a write+readback sequence completes, whether it passed or failed.
- err  out  1  sticky; set on readback mismatch or timeout.
- rd_data  out  32  last value captured on a read ack.

Behaviour:
- Synchronisers
  - sw_in and btn_go each pass through 2 FFs.
  - Debounce counter restarts on any change of the synchronised button. The debounced level updates when the counter reaches DEBOUNCE_CYCLES-1.
  - go_evt is a one-cycle pulse on a rising edge of the debounced level.
- On reset (reset==0 at a clk edge), all of the following clear on that edge, including mid-transaction: cyc, stb, we, dat_o, busy, done, err, rd_data, counters, sync FFs. State = IDLE.
- FSM states and transitions:
  - IDLE
    - On go_evt: latch wb_dat_o <= {16'b0, sw_sync}. Assert cyc=stb=we=1 and busy. Clear tmo. Next state WR.
  - WR
    - Hold all bus signals stable until wb_ack_i.
    - On ack: drop cyc/stb/we on the next edge and go to GAP.
    - If tmo reaches TIMEOUT_CYCLES: drop the bus, set err, go to FIN.
  - GAP
    - One idle cycle with cyc=stb=0, so a target with a registered ack sees stb low.
    - Then assert cyc=stb=1, we=0, clear tmo. Next state RD.
  - RD
    - On ack: capture rd_data <= wb_dat_i and drop the bus.
    - If wb_dat_i != wb_dat_o, set err.
    - Next state FIN.
    - Timeout handling is identical to WR.
  - FIN
    - Pulse done for one cycle, deassert busy, return to IDLE.
- Bus rules
  - stb is never asserted without cyc.
  - adr and sel are constant.
  - wb_dat_o changes only in IDLE.
- Latency with a target that acks 1 cycle after stb rises:
  - go_evt to first stb: 1 cycle.
  - go_evt to done: 7 cycles.
- go_evt while busy is ignored; it is not queued.
- The tmo counter saturates and does not wrap.
- err stays set across transactions; only reset clears it. The next successful sequence does not clear err.
- wb_ack_i outside WR/RD is ignored.

Decomposition:
- Shared package / header holds:
  - FSM state encodings: IDLE=0, WR=1, GAP=2, RD=3, FIN=4, 3-bit.
  - Wishbone sel constant SEL_ALL = 4'b1111.
  - Default TARGET_ADR.
- One sub-module is natural: sw_debounce. It takes clk, reset, raw input and DEBOUNCE_CYCLES, and outputs the level and a rise pulse. It is instantiated once for btn_go; switches are only synchronised.

Test Plan:
1. Reset held low 5 cycles mid-WR -> cyc/stb/busy/err = 0 on the first edge with reset low; FSM in IDLE after release.
2. sw_in=16'hA5C3, btn pressed with a 20-cycle bounce then held (DEBOUNCE_CYCLES=8 in bench) -> exactly one write: wb_dat_o=32'h0000A5C3, adr=0x10, sel=F. Then one read; bench target returns 32'h0000A5C3; done pulses; err stays 0.
3. Target returns 32'h0000A5C2 on readback -> rd_data=32'h0000A5C2, err=1, done pulses once; err stays 1 after a following passing sequence.
4. Target never acks (TIMEOUT_CYCLES=15) -> cyc drops after 15 cycles in WR, err=1, done pulses, no read issued.
5. Second button press while busy -> ignored: only one write and one read observed, busy continuous.
6. Target with registered ack (ack high 1 cycle after stb) -> stb low for exactly 1 cycle between write ack and read stb; go_evt to done = 7 cycles.
